// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// unified_mem_ctrl : shared instruction/data word memory with a combinational
// fetch port and a fixed-latency request/response data port.
// Optional simulation checks: define MEM_ASSERT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module unified_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   PC,
  output logic [DATA_W-1:0]   instruction,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic                d_busy,
  output logic                d_valid,
  output logic [DATA_W-1:0]   data_out,
  output logic                d_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       resp, capture;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              q_we, q_err;
  logic [BE_W-1:0]   q_be;
  logic [IDX_W-1:0]  q_idx;
  logic [DATA_W-1:0] q_din;

  logic              r_we, r_err;
  logic [BE_W-1:0]   r_be;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_din;

  logic             pc_oor, pc_mis, da_oor, da_mis;
  logic [IDX_W-1:0] pc_idx, da_idx;

  // Shifting avoids a zero-width slice when ADDR_W == IDX_W+2.
  assign pc_oor = |(PC >> (IDX_W + 2));
  assign da_oor = |(data_addr >> (IDX_W + 2));
  assign pc_mis = |PC[1:0];
  assign da_mis = |data_addr[1:0];
  assign pc_idx = PC[IDX_W+1:2];
  assign da_idx = data_addr[IDX_W+1:2];

  assign instruction = pc_oor ? '0 : mem[pc_idx];
  assign i_err       = pc_oor | pc_mis;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    resp    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          resp    = 1'b1;
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the response fires on the accepting edge from live inputs.
  always_comb begin
    if (state == IDLE) begin
      r_we  = d_we;
      r_be  = d_be;
      r_idx = da_idx;
      r_din = data_in;
      r_err = da_oor | da_mis;
    end else begin
      r_we  = q_we;
      r_be  = q_be;
      r_idx = q_idx;
      r_din = q_din;
      r_err = q_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      d_busy   <= 1'b0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      data_out <= '0;
      q_we     <= 1'b0;
      q_err    <= 1'b0;
      q_be     <= '0;
      q_idx    <= '0;
      q_din    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      d_busy  <= (state_n == WAIT);
      d_valid <= resp;
      if (capture) begin
        q_we  <= d_we;
        q_be  <= d_be;
        q_idx <= da_idx;
        q_din <= data_in;
        q_err <= da_oor | da_mis;
      end
      if (resp) begin
        d_err <= r_err;
        if (r_err)
          data_out <= '0;
        else if (!r_we)
          data_out <= mem[r_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && resp && r_we && !r_err) begin
      for (int k = 0; k < BE_W; k++) begin
        if (r_be[k])
          mem[r_idx][8*k +: 8] <= r_din[8*k +: 8];
      end
    end
  end

`ifdef MEM_ASSERT_EN
  always @(posedge clk) begin
    if (!rst && state == IDLE && d_req) begin
      if (da_mis)
        $warning("unified_mem_ctrl: misaligned data access at 0x%h", data_addr);
      if (da_oor) begin
        $error("unified_mem_ctrl: out-of-range data access at 0x%h", data_addr);
        $stop;
      end
    end
  end

  always @(PC) begin
    if (!$isunknown(PC)) begin
      if (|(PC >> (IDX_W + 2))) begin
        $error("unified_mem_ctrl: out-of-range PC 0x%h", PC);
        $stop;
      end else if (|PC[1:0]) begin
        $warning("unified_mem_ctrl: misaligned PC 0x%h", PC);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_unified_mem_ctrl : table-driven + scoreboard bench for unified_mem_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_unified_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC = '0;
  logic [31:0] instruction;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_in = '0;
  logic        d_busy, d_valid, d_err;
  logic [31:0] data_out;

  unified_mem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(4096), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .PC(PC), .instruction(instruction), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .data_addr(data_addr),
    .data_in(data_in), .d_busy(d_busy), .d_valid(d_valid),
    .data_out(data_out), .d_err(d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  resp_t sb[$];
  vec_t  vecs[21];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every response is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (d_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_d_valid", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("sb_data_out", data_out, e.data);
        check("sb_d_err", {31'd0, d_err}, {31'd0, e.err});
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] ed, input logic ee);
    resp_t r;
    d_req = 1'b1; d_we = we; d_be = be; data_addr = addr; data_in = din;
    r.data = ed; r.err = ee;
    sb.push_back(r);
  endtask

  task automatic run_access(input vec_t v);
    int n;
    n = 0;
    while (d_busy && n < 20) begin step(); n++; end
    if (d_busy) check("busy_timeout", 32'd1, 32'd0);
    PC = v.addr;
    drive(v.we, v.be, v.addr, v.din, v.exp_data, v.exp_err);
    step();
    d_req = 1'b0;
    check("busy_in_flight", {31'd0, d_busy}, 32'd1);
    n = 1;
    while (!d_valid && n < 20) begin step(); n++; end
    check("latency", n, LAT);
    check("i_err_vs_addr", {31'd0, i_err}, {31'd0, v.exp_err});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h0102_0304, 1'b0};
    vecs[1]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0102_0304, 1'b0};
    vecs[2]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0102_0304, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
    vecs[4]  = '{1'b1, 4'hF, 32'h0000_0024, 32'hCAFE_F00D, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF, 32'h11BB_33DD, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 32'h0000_0024, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_0022, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 4'hF, 32'h0000_3FFC, 32'h7654_3210, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 4'hA, 32'h0000_3FFC, 32'h0BAD_C0DE, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 4'h0, 32'h0000_3FFC, 32'h0,         32'h0B54_C010, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 32'h0000_3FFE, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
    vecs[13] = '{1'b1, 4'hF, 32'h0000_0000, 32'h1357_9BDF, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h1357_9BDF, 1'b0};
    vecs[15] = '{1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678, 32'h0,         1'b1};
    vecs[16] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h1357_9BDF, 1'b0};
    vecs[17] = '{1'b1, 4'hF, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[18] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
    vecs[19] = '{1'b1, 4'hF, 32'h0000_4000, 32'h5555_AAAA, 32'h0,         1'b1};
    vecs[20] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h1357_9BDF, 1'b0};

    // Reset, then idle.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    check("rst_d_busy",   {31'd0, d_busy},  32'd0);
    check("rst_d_valid",  {31'd0, d_valid}, 32'd0);
    check("rst_d_err",    {31'd0, d_err},   32'd0);
    check("rst_data_out", data_out,         32'd0);

    // Write then back-to-back read, with exact cycle timing.
    PC = 32'h10;
    drive(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    step();
    d_req = 1'b0;
    check("wr_busy_T1",  {31'd0, d_busy},  32'd1);
    check("wr_valid_T1", {31'd0, d_valid}, 32'd0);
    step();
    check("wr_valid_T2", {31'd0, d_valid}, 32'd1);
    check("wr_busy_T2",  {31'd0, d_busy},  32'd0);
    check("ifetch_T2",   instruction,      32'hDEAD_BEEF);
    drive(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    step();
    d_req = 1'b0;
    check("rd_busy_T3", {31'd0, d_busy}, 32'd1);
    step();
    check("rd_valid_T4", {31'd0, d_valid}, 32'd1);
    check("rd_data_T4",  data_out,         32'hDEAD_BEEF);

    // Instruction port shows the pre-commit word during the commit cycle.
    drive(1'b1, 4'hF, 32'h10, 32'h0102_0304, 32'hDEAD_BEEF, 1'b0);
    step();
    d_req = 1'b0;
    check("ifetch_commit_cycle", instruction, 32'hDEAD_BEEF);
    step();
    check("ifetch_after_commit", instruction, 32'h0102_0304);

    for (int i = 0; i < 21; i++) run_access(vecs[i]);
    step();

    // Instruction port error cases.
    PC = 32'h0001_0000;
    #1;
    check("ifetch_oor_data", instruction, 32'h0);
    check("ifetch_oor_err",  {31'd0, i_err}, 32'd1);
    PC = 32'h12;
    #1;
    check("ifetch_mis_data", instruction, 32'h0102_0304);
    check("ifetch_mis_err",  {31'd0, i_err}, 32'd1);

    // Held request: second one ignored while busy, accepted in the valid cycle.
    drive(1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB_33DD, 1'b0);
    step();
    data_addr = 32'h24;
    check("held_busy_T1", {31'd0, d_busy}, 32'd1);
    begin
      resp_t r;
      r.data = 32'hCAFE_F00D; r.err = 1'b0;
      sb.push_back(r);
    end
    step();
    check("held_valid_T2", {31'd0, d_valid}, 32'd1);
    step();
    d_req = 1'b0;
    check("held_busy_T3", {31'd0, d_busy}, 32'd1);
    step();
    check("held_valid_T4", {31'd0, d_valid}, 32'd1);
    check("held_data_T4",  data_out,         32'hCAFE_F00D);
    step();
    check("held_no_third", {31'd0, d_valid}, 32'd0);

    // Reset during an in-flight write drops it.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; data_addr = 32'h20; data_in = 32'h0;
    step();
    d_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_valid", {31'd0, d_valid}, 32'd0);
      check("rst_mid_no_busy",  {31'd0, d_busy},  32'd0);
      step();
    end
    check("rst_mid_data_out", data_out, 32'h0);
    begin
      vec_t v;
      v = '{1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB_33DD, 1'b0};
      run_access(v);
    end
    step();
    step();
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Parametrised unified instruction/data memory for the CPU, replacing the fixed 32-bit, 16 KiB memory.
- Instruction fetch port: combinational read.
- Data port: request/response handshake with configurable access latency, byte-lane write enables, and a per-access error flag for misaligned or out-of-range addresses.
- Sits between the core's fetch/LSU stages and the single backing word array.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 4096, number of words; power of two. IDX_W = log2(DEPTH_WORDS). Requires ADDR_W >= IDX_W+2.
- LATENCY, 2, cycles from request acceptance to response; range 1..15.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- PC  input  ADDR_W  instruction byte address.
- instruction  output  DATA_W  combinational word at PC.
- i_err  output  1  combinational; PC misaligned or out of range.
- d_req  input  1  data request.
- d_we  input  1  1 = write, 0 = read.
- d_be  input  DATA_W/8  byte-lane write enables; lane k is bits 8k+7:8k.
- data_addr  input  ADDR_W  data byte address.
- data_in  input  DATA_W  write data.
- d_busy  output  1  registered; request in flight, new requests ignored.
- d_valid  output  1  registered one-cycle response strobe.
- data_out  output  DATA_W  registered read data, held until the next response.
- d_err  output  1  registered; qualifies d_valid.

## Operation
- Word index: addr[IDX_W+1:2].
- Misaligned: addr[1:0] != 0.
- Out of range: any of addr[ADDR_W-1:IDX_W+2] != 0.
- Instruction port:
  - instruction = mem[PC index] when PC is in range; otherwise instruction = 0.
  - i_err = misaligned | out-of-range.
- FSM states: IDLE and WAIT, with a down-counter cnt.
  - Acceptance: d_req=1 and d_busy=0. On acceptance, latch d_we, d_be, data_addr and data_in, and compute err.
  - LATENCY=1: stay in IDLE; the response is issued on the next edge.
  - LATENCY>1: go to WAIT with cnt=LATENCY-1. Each WAIT cycle decrements cnt. At cnt=1, the edge issues the response and returns to IDLE.
- Response edge:
  - Sets d_valid=1 for one cycle and d_err=err.
  - Read, no error: data_out = mem[index] sampled at that edge, i.e. before any commit on the same edge.
  - Write, no error: commits lanes with d_be[k]=1 on that edge. data_out is unchanged.
  - Error: no write, data_out = 0.
- d_be is ignored on reads. A write with d_be=0 completes normally with no change to memory.
- Memory contents are not reset and power up X.
- With no request in flight, d_req=0 leaves all state unchanged.

## Timing
- Reset values: FSM IDLE, cnt=0, d_busy=0, d_valid=0, d_err=0, data_out=0.
- Reset mid-operation: the pending access is dropped, no write commits, and no d_valid is issued.
- Request accepted in cycle T:
  - d_busy=1 in cycles T+1..T+LATENCY-1; never high when LATENCY=1.
  - d_valid=1 in cycle T+LATENCY.
  - A write is visible on instruction (and to later data reads) from cycle T+LATENCY.
- Back-to-back: d_busy=0 in the d_valid cycle, so a new request may be accepted there. Throughput is one access per LATENCY cycles.
- d_req while d_busy=1: ignored, not queued. The master must hold or re-assert d_req.
- The instruction read during a commit cycle returns the pre-commit word. The new word appears the cycle after the edge.
- Inputs are sampled only at acceptance; they may change freely afterwards.

## Configuration
- MEM_ASSERT_EN (simulation-only checks):
  - Defined, data port: every accepted misaligned access prints a warning with the address.
  - Defined, data port: every accepted out-of-range access prints an error and calls $stop.
  - Defined, instruction port: every change of PC to a misaligned value prints a warning; to an out-of-range value, prints an error and calls $stop.
  - Undefined: no checking code is compiled. Errors are reported only through d_err/i_err.
  - Functional outputs are identical either way.

## Test plan
- Reset, then idle 5 cycles -> d_busy, d_valid, d_err and data_out all 0.
- LATENCY=2: write 0xDEADBEEF to 0x10 with d_be=0xF, accepted at T; read 0x10 accepted at T+2 -> d_busy=1 at T+1, d_valid at T+2 and T+4, data_out=0xDEADBEEF at T+4; PC=0x10 shows 0xDEADBEEF from T+2.
- Word at 0x20 = 0x11223344; write 0xAABBCCDD to 0x20 with d_be=0b0101 -> read returns 0x11BB33DD.
- Read of 0x22 and write of 0x0001_0000 (16 KiB default) -> d_valid with d_err=1, data_out=0, memory unchanged; with MEM_ASSERT_EN the bench expects a warning, then $stop on the second access.
- Request at T with a second d_req held through T+1 -> second request ignored at T+1, accepted at T+2, d_valid at T+4.
- Write accepted at T with rst=1 at T+1 -> no d_valid issued; a subsequent read of the address returns the old contents.
